escaner_teclado_param: RTL and testbench

Parametrised matrix-keypad scanner that drives a ROWS x COLS key matrix and debounces both press and release. Each accepted key press is converted to a linear key code and stored in a small FIFO, and the FIFO is drained through a valid/ready handshake. It is the successor to the fixed 4x4 hex keypad interface. Compared with that interface it adds generic matrix size, configurable scan and debounce timing, buffering of up to FIFO_DEPTH keystrokes, and a sticky overflow flag. It sits between the keypad pins and the consumer logic (display/ALU input).

---
 rtl/escaner_teclado_param.sv | 207 ++++++++++++++++++++
 tb/tb_escaner_teclado_param.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/escaner_teclado_param.sv
// Matrix keypad scanner: one-hot column scan, press/release debounce, and a
// key-code FIFO drained by valid/ready with a sticky overflow flag.
module escaner_teclado_param #(
   parameter int unsigned ROWS            = 4,
   parameter int unsigned COLS            = 4,
   parameter int unsigned SCAN_CYCLES     = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 8,
   parameter int unsigned FIFO_DEPTH      = 4,
   localparam int unsigned CODE_W         = $clog2(ROWS * COLS),
   localparam int unsigned CNT_W          = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [ROWS-1:0]   filas_i,
   output logic [COLS-1:0]   columnas_o,
   output logic [CODE_W-1:0] key_code_o,
   output logic              key_valid_o,
   input  logic              key_ready_i,
   output logic [CNT_W-1:0]  fifo_count_o,
   output logic              overflow_o,
   input  logic              clear_overflow_i
);

   localparam int unsigned ROW_W   = $clog2(ROWS);
   localparam int unsigned COL_W   = $clog2(COLS);
   localparam int unsigned DWELL_W = $clog2(SCAN_CYCLES);
   localparam int unsigned DEB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);

   localparam logic [DWELL_W-1:0] DwellLast = DWELL_W'(SCAN_CYCLES - 1);
   localparam logic [DEB_W-1:0]   DebLast   = DEB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [COL_W-1:0]   ColLast   = COL_W'(COLS - 1);
   localparam logic [CNT_W-1:0]   CntFull   = CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {StScan, StDebounce, StHeld} state_e;

   // Two-flop synchroniser; rs_q is the only view of the rows used below.
   logic [ROWS-1:0]    meta_q, meta_d;
   logic [ROWS-1:0]    rs_q, rs_d;

   state_e             state_q, state_d;
   logic [COL_W-1:0]   col_q, col_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic [DEB_W-1:0]   deb_q, deb_d;

   logic [CODE_W-1:0]  mem_q [FIFO_DEPTH];
   logic [CODE_W-1:0]  mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               overflow_q, overflow_d;

   logic [ROW_W-1:0]   low_row;
   logic [COL_W-1:0]   col_next;
   logic [CODE_W-1:0]  push_code;
   logic               push;
   logic               pop;
   logic               full;
   logic               do_push;

   assign meta_d = filas_i;
   assign rs_d   = meta_q;

   // Lowest-index asserted row wins when several rows are closed.
   always_comb begin
      low_row = '0;
      for (int i = ROWS - 1; i >= 0; i--) begin
         if (rs_q[i]) begin
            low_row = ROW_W'(i);
         end
      end
   end

   assign col_next  = (col_q == ColLast) ? '0 : col_q + COL_W'(1);
   assign push_code = CODE_W'(32'(row_q) * COLS + 32'(col_q));

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      dwell_d = dwell_q;
      deb_d   = deb_q;
      push    = 1'b0;
      unique case (state_q)
         StScan: begin
            if (dwell_q == DwellLast) begin
               dwell_d = '0;
               if (|rs_q) begin
                  row_d   = low_row;
                  deb_d   = '0;
                  state_d = StDebounce;
               end else begin
                  col_d = col_next;
               end
            end else begin
               dwell_d = dwell_q + DWELL_W'(1);
            end
         end
         StDebounce: begin
            if (rs_q[row_q]) begin
               if (deb_q == DebLast) begin
                  push    = 1'b1;
                  deb_d   = '0;
                  state_d = StHeld;
               end else begin
                  deb_d = deb_q + DEB_W'(1);
               end
            end else begin
               deb_d   = '0;
               col_d   = col_next;
               state_d = StScan;
            end
         end
         StHeld: begin
            // Release must be seen as an unbroken run of zeros.
            if (rs_q[row_q]) begin
               deb_d = '0;
            end else if (deb_q == DebLast) begin
               deb_d   = '0;
               col_d   = col_next;
               state_d = StScan;
            end else begin
               deb_d = deb_q + DEB_W'(1);
            end
         end
         default: begin
            state_d = StScan;
         end
      endcase
   end

   always_comb begin
      columnas_o        = '0;
      columnas_o[col_q] = 1'b1;
   end

   assign pop     = (count_q != '0) && key_ready_i;
   assign full    = (count_q == CntFull);
   assign do_push = push && (!full || pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_code;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!do_push && pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // A new drop in the same cycle as a clear keeps the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (clear_overflow_i) begin
         overflow_d = 1'b0;
      end
      if (push && full && !pop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q     <= '0;
         rs_q       <= '0;
         state_q    <= StScan;
         col_q      <= '0;
         row_q      <= '0;
         dwell_q    <= '0;
         deb_q      <= '0;
         mem_q      <= '{default: '0};
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         meta_q     <= meta_d;
         rs_q       <= rs_d;
         state_q    <= state_d;
         col_q      <= col_d;
         row_q      <= row_d;
         dwell_q    <= dwell_d;
         deb_q      <= deb_d;
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign key_code_o   = mem_q[rd_ptr_q];
   assign key_valid_o  = (count_q != '0);
   assign fifo_count_o = count_q;
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_escaner_teclado_param.sv
// Bench for escaner_teclado_param: a physical keypad model drives the rows,
// and a queue of expected key codes checks every popped code and the flags.
module tb_escaner_teclado_param;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int DEPTH = 4;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic [3:0] filas_i;
   logic [3:0] columnas_o;
   logic [3:0] key_code_o;
   logic       key_valid_o;
   logic       key_ready_i;
   logic [2:0] fifo_count_o;
   logic       overflow_o;
   logic       clear_overflow_i;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_fail   = 0;
   int   pops     = 0;
   int   pre;
   int   exp_q[$];
   logic model_ovf;
   bit   rand_ready = 1'b0;

   logic [1:0] key_row;
   logic [1:0] key_col;
   bit         key_down;

   escaner_teclado_param #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_CYCLES(4), .DEBOUNCE_CYCLES(8), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .filas_i(filas_i),
      .columnas_o(columnas_o),
      .key_code_o(key_code_o),
      .key_valid_o(key_valid_o),
      .key_ready_i(key_ready_i),
      .fifo_count_o(fifo_count_o),
      .overflow_o(overflow_o),
      .clear_overflow_i(clear_overflow_i)
   );

   always #5 clk_i = ~clk_i;

   // A closed key connects its column drive to its row sense line.
   always_comb begin
      filas_i = '0;
      if (key_down && columnas_o[key_col]) filas_i[key_row] = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
   endtask

   // Inputs are stable here, so a visible valid && ready pops on the coming edge.
   task automatic tick();
      if (key_valid_o === 1'b1 && key_ready_i === 1'b1) begin
         pops++;
         if (exp_q.size() == 0) check("spurious_pop", 32'(key_valid_o), 32'(0));
         else check("pop_code", 32'(key_code_o), 32'(exp_q.pop_front()));
      end
      @(posedge clk_i);
      #1;
      if (rand_ready) key_ready_i = 1'($urandom_range(0, 1));
   endtask

   task automatic model_push(input int code);
      if (exp_q.size() < DEPTH) exp_q.push_back(code);
      else model_ovf = 1'b1;
   endtask

   task automatic press(input int r, input int c, input int hold, input int gap);
      model_push(r * COLS + c);
      key_row  = 2'(r);
      key_col  = 2'(c);
      key_down = 1'b1;
      repeat (hold) tick();
      key_down = 1'b0;
      repeat (gap) tick();
   endtask

   // Returns in the first cycle the target column is driven.
   task automatic wait_col(input logic [3:0] target);
      for (int i = 0; i < 20 && columnas_o === target; i++) tick();
      for (int i = 0; i < 40 && columnas_o !== target; i++) tick();
      check("wait_col", 32'(columnas_o), 32'(target));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_i          = 1'b1;
      key_ready_i      = 1'b0;
      clear_overflow_i = 1'b0;
      key_down         = 1'b0;
      key_row          = '0;
      key_col          = '0;
      model_ovf        = 1'b0;
      tick();
      tick();
      reset_i = 1'b0;

      // Reset state and scan rotation.
      check("rst_cols", 32'(columnas_o), 32'(4'b0001));
      check("rst_valid", 32'(key_valid_o), 32'(0));
      check("rst_count", 32'(fifo_count_o), 32'(0));
      check("rst_ovf", 32'(overflow_o), 32'(0));
      check("rst_code", 32'(key_code_o), 32'(0));
      repeat (3) tick();
      check("dwell_hold", 32'(columnas_o), 32'(4'b0001));
      tick();
      check("col1", 32'(columnas_o), 32'(4'b0010));
      repeat (11) tick();
      check("col3", 32'(columnas_o), 32'(4'b1000));
      tick();
      check("col_wrap", 32'(columnas_o), 32'(4'b0001));

      // Clean press of row 2 / column 1 -> one code 9.
      key_ready_i = 1'b1;
      pre = pops;
      press(2, 1, 60, 60);
      check("clean_pops", 32'(pops - pre), 32'(1));
      check("clean_left", 32'(exp_q.size()), 32'(0));
      check("clean_count", 32'(fifo_count_o), 32'(0));

      // Five-cycle bounce on column 3 is rejected.
      wait_col(4'b1000);
      key_row  = 2'd0;
      key_col  = 2'd3;
      key_down = 1'b1;
      repeat (5) tick();
      key_down = 1'b0;
      tick();
      check("bounce_frozen", 32'(columnas_o), 32'(4'b1000));
      repeat (2) tick();
      check("bounce_resume", 32'(columnas_o), 32'(4'b0001));
      repeat (20) tick();
      check("bounce_count", 32'(fifo_count_o), 32'(0));
      check("bounce_valid", 32'(key_valid_o), 32'(0));

      // Overflow and ordering with the consumer stalled.
      key_ready_i = 1'b0;
      press(0, 1, 40, 30);
      press(1, 0, 40, 30);
      press(1, 3, 40, 30);
      press(2, 2, 40, 30);
      press(3, 3, 40, 30);
      check("ovf_count", 32'(fifo_count_o), 32'(exp_q.size()));
      check("ovf_flag", 32'(overflow_o), 32'(model_ovf));
      check("ovf_head", 32'(key_code_o), 32'(exp_q[0]));
      key_ready_i = 1'b1;
      repeat (10) tick();
      check("ovf_drained", 32'(exp_q.size()), 32'(0));
      check("ovf_count0", 32'(fifo_count_o), 32'(0));
      check("ovf_sticky", 32'(overflow_o), 32'(model_ovf));
      clear_overflow_i = 1'b1;
      tick();
      clear_overflow_i = 1'b0;
      model_ovf        = 1'b0;
      check("ovf_clear", 32'(overflow_o), 32'(model_ovf));

      // Full FIFO with pop in the push cycle.
      key_ready_i = 1'b0;
      press(0, 2, 40, 30);
      press(1, 1, 40, 30);
      press(2, 0, 40, 30);
      press(2, 3, 40, 30);
      check("full_count", 32'(fifo_count_o), 32'(4));
      wait_col(4'b0010);
      key_row  = 2'd3;
      key_col  = 2'd1;
      key_down = 1'b1;
      // Detection at dwell 3, then eight debounce cycles: push at the 12th cycle.
      repeat (11) tick();
      key_ready_i = 1'b1;
      tick();
      key_ready_i = 1'b0;
      model_push(13);
      check("pp_count", 32'(fifo_count_o), 32'(exp_q.size()));
      check("pp_ovf", 32'(overflow_o), 32'(model_ovf));
      repeat (20) tick();
      key_down = 1'b0;
      repeat (30) tick();
      check("pp_count_hold", 32'(fifo_count_o), 32'(4));
      key_ready_i = 1'b1;
      repeat (10) tick();
      check("pp_drained", 32'(exp_q.size()), 32'(0));
      check("pp_count0", 32'(fifo_count_o), 32'(0));

      // Reset while a key is held with two entries buffered.
      key_ready_i = 1'b0;
      press(1, 2, 40, 30);
      model_push(14);
      key_row  = 2'd3;
      key_col  = 2'd2;
      key_down = 1'b1;
      repeat (40) tick();
      check("mid_count", 32'(fifo_count_o), 32'(exp_q.size()));
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      exp_q.delete();
      model_ovf = 1'b0;
      check("mid_rst_count", 32'(fifo_count_o), 32'(0));
      check("mid_rst_valid", 32'(key_valid_o), 32'(0));
      check("mid_rst_cols", 32'(columnas_o), 32'(4'b0001));
      model_push(14);
      repeat (40) tick();
      check("redetect_count", 32'(fifo_count_o), 32'(exp_q.size()));
      check("redetect_code", 32'(key_code_o), 32'(14));
      key_down = 1'b0;
      repeat (40) tick();
      check("redetect_once", 32'(fifo_count_o), 32'(1));
      key_ready_i = 1'b1;
      repeat (5) tick();
      check("redetect_drained", 32'(exp_q.size()), 32'(0));

      // Random keys with a randomly stalling consumer.
      pre        = pops;
      rand_ready = 1'b1;
      for (int k = 0; k < 12; k++) begin
         press(int'($urandom_range(0, ROWS - 1)), int'($urandom_range(0, COLS - 1)),
               int'($urandom_range(40, 70)), int'($urandom_range(25, 50)));
      end
      rand_ready  = 1'b0;
      key_ready_i = 1'b1;
      repeat (10) tick();
      check("rand_pops", 32'(pops - pre), 32'(12));
      check("rand_left", 32'(exp_q.size()), 32'(0));
      check("rand_count", 32'(fifo_count_o), 32'(0));
      check("rand_ovf", 32'(overflow_o), 32'(model_ovf));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
